encoder_pass_sched: RTL and testbench
=====================================

Name: encoder_pass_sched

Overview:
- Sequencer that runs a chain of matrix-encoder function units over a 64-line × 25-bit state held in two ping-pong banks.
- Launches each unit in turn, for NUM_FUNCS units × NUM_ROUNDS rounds, with a start/done handshake.
- Generates the read and write addresses and bank selects for the shared state memories, checks that every pass writes exactly LINES lines, and guards each pass with a watchdog.
- Sits between the top-level start/done interface and the function units (column parity and the following stages).

Parameters:
- NUM_FUNCS, 3, number of function units chained per round.
- NUM_ROUNDS, 2, number of times the full chain runs.
- LINES, 64, lines per state bank; one pass must write exactly LINES lines.
- ADDR_W, 6, line address width; LINES = 2**ADDR_W.
- FSEL_W, 2, unit-select width; NUM_FUNCS <= 2**FSEL_W.
- TIMEOUT, 255, maximum cycles allowed in WAIT per pass.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level request; a run begins on the 0→1 edge seen while idle.
- done  out  1  one-cycle pulse at the end of a run, successful or errored.
- busy  out  1  high from launch until the done cycle, inclusive.
- error  out  1  sticky; valid with done; cleared at the next accepted start.
- fu_sel  out  FSEL_W  index of the active unit.
- fu_start  out  1  one-cycle launch pulse to the selected unit.
- fu_done  in  1  one-cycle completion pulse from the selected unit.
- fu_cnt  in  ADDR_W  line counter of the active unit.
- fu_wr_en  in  1  write strobe of the active unit.
- rd_bank  out  1  bank the unit reads from.
- rd_addr  out  ADDR_W  read address = (fu_cnt + LINES − 1) mod LINES; combinational.
- wr_bank  out  1  always the inverse of rd_bank.
- wr_addr  out  ADDR_W  current write line.
- mem_we  out  1  fu_wr_en gated by state == WAIT; combinational.
- result_bank  out  1  bank holding the final state; valid from done onward.

Behaviour:
- Reset values (rst low, asynchronous):
  - state = IDLE.
  - done, busy, error, fu_start, fu_sel, rd_bank, result_bank, wr_addr, step, round, write count, watchdog = 0.
- A reset in the middle of a run aborts it immediately; no done pulse is produced.
- IDLE:
  - Register start into start_q.
  - When start & ~start_q: clear error, set step = 0, round = 0, rd_bank = 0, go to LAUNCH.
  - start held high after a run does not restart the block.
- LAUNCH (1 cycle):
  - fu_start = 1, fu_sel = step.
  - Clear wr_addr, the write count and the watchdog.
  - Go to WAIT.
- WAIT:
  - Each fu_wr_en increments wr_addr (wrapping mod LINES) and the write count (saturating at LINES + 1).
  - The watchdog increments every cycle.
  - On fu_done:
    - If write count ≠ LINES → error = 1, go to FINISH.
    - Otherwise go to SWAP.
  - fu_wr_en and fu_done in the same cycle: the write is counted before the check.
  - Watchdog reaching TIMEOUT without fu_done → error = 1, go to FINISH.
- SWAP (1 cycle):
  - Toggle rd_bank.
  - If step == NUM_FUNCS − 1: step = 0 and round increments; otherwise step increments.
  - If the last step of the last round has completed → FINISH; otherwise → LAUNCH.
- FINISH (1 cycle):
  - done = 1.
  - result_bank = rd_bank (already toggled by the last SWAP).
  - Go to IDLE; busy drops the following cycle.
- Inputs outside their valid window:
  - fu_done outside WAIT is ignored.
  - fu_wr_en outside WAIT gives mem_we = 0 and is not counted.
  - start while busy is ignored.
- Latency per successful pass: unit latency + 2 cycles (LAUNCH, SWAP). FINISH adds 1 cycle per run.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LAUNCH, WAIT, SWAP, FINISH);
  - constants LINES and ADDR_W;
  - a function computing rd_addr from fu_cnt.
- One natural sub-module: pass_watchdog (clear, enable, TIMEOUT compare, expired flag).

Test Plan:
- Nominal run, NUM_FUNCS=3, NUM_ROUNDS=2, model unit writes 64 lines then pulses fu_done → 6 fu_start pulses; fu_sel sequence 0,1,2,0,1,2; rd_bank 0,1,0,1,0,1 at each launch; single done pulse; error=0; result_bank=0.
- Address mapping: fu_cnt=0 → rd_addr=63; fu_cnt=5 → rd_addr=4. After 64 writes wr_addr wraps to 0; mem_we mirrors fu_wr_en only in WAIT.
- Short pass: unit writes 63 lines then fu_done on pass 2 → error=1 and done pulses 1 cycle later; no third fu_start. Repeating with 65 writes gives the same result.
- Timeout: unit never returns fu_done → error=1 and done exactly TIMEOUT cycles after WAIT entry plus 1.
- Reset mid-run: rst low during round 1, step 1 → all outputs go to reset values immediately, no done. A fresh start edge then runs the full 6-pass sequence cleanly.
- Start handling: start held high through done → no relaunch. Start toggled 1→0→1 → a new run begins with error cleared. A start edge while busy is ignored.

Source files
------------

// File: rtl/encoder_pass_sched_pkg.sv
// Shared definitions for the encoder pass sequencer: state codes, state-bank
// geometry and the read-address mapping used by every function unit.
package encoder_pass_sched_pkg;

  localparam int ADDR_W = 6;
  localparam int LINES  = 2 ** ADDR_W;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LAUNCH = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_SWAP   = 3'd3;
  localparam state_t S_FINISH = 3'd4;

  // Units present the line they are about to produce; the source line is one
  // behind, wrapping so that line 0 reads the last line of the bank.
  function automatic logic [ADDR_W-1:0] rd_addr_of(input logic [ADDR_W-1:0] cnt);
    return cnt - ADDR_W'(1);
  endfunction

endpackage

// File: rtl/encoder_pass_sched_watchdog.sv
// Per-pass watchdog: counts enabled cycles since the last clear and flags
// expiry once the count has reached TIMEOUT.
module pass_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled and hold at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != WD_W'(TIMEOUT))) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == WD_W'(TIMEOUT));

endmodule

// File: rtl/encoder_pass_sched.sv
// Sequencer running NUM_FUNCS encoder units for NUM_ROUNDS rounds over a
// ping-pong pair of state banks, with per-pass line-count and watchdog checks.
//
//   state  | meaning
//   IDLE   | waiting for a rising start edge
//   LAUNCH | one-cycle fu_start to unit `step`, pass counters cleared
//   WAIT   | unit running; writes counted, watchdog running
//   SWAP   | pass accepted; flip banks and advance step/round
//   FINISH | one-cycle done pulse, result bank published
module encoder_pass_sched
  import encoder_pass_sched_pkg::*;
#(
  parameter int NUM_FUNCS  = 3,
  parameter int NUM_ROUNDS = 2,
  parameter int FSEL_W     = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic              error,
  output logic [FSEL_W-1:0] fu_sel,
  output logic              fu_start,
  input  logic              fu_done,
  input  logic [ADDR_W-1:0] fu_cnt,
  input  logic              fu_wr_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              mem_we,
  output logic              result_bank
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(LINES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(LINES);
  localparam logic [FSEL_W-1:0] LAST_STEP  = FSEL_W'(NUM_FUNCS - 1);
  localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(NUM_ROUNDS - 1);

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [FSEL_W-1:0] step_q, step_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic              rd_bank_q, rd_bank_d;
  logic              result_bank_q, result_bank_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              wd_expired;

  pass_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_LAUNCH),
    .en      (state_q == S_WAIT),
    .expired (wd_expired)
  );

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    start_d       = start;
    step_d        = step_q;
    round_d       = round_q;
    rd_bank_d     = rd_bank_q;
    result_bank_d = result_bank_q;
    error_d       = error_q;
    wr_addr_d     = wr_addr_q;
    wr_cnt_d      = wr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          error_d   = 1'b0;
          step_d    = '0;
          round_d   = '0;
          rd_bank_d = 1'b0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wr_addr_d = '0;
        wr_cnt_d  = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (fu_wr_en) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_cnt_q != CNT_SAT) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        // A write in the completion cycle is already folded into wr_cnt_d.
        if (fu_done) begin
          if (wr_cnt_d != CNT_FULL) begin
            error_d = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_SWAP;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_SWAP: begin
        rd_bank_d = !rd_bank_q;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          round_d = round_q + RND_W'(1);
          state_d = (round_q == LAST_ROUND) ? S_FINISH : S_LAUNCH;
        end else begin
          step_d  = step_q + FSEL_W'(1);
          state_d = S_LAUNCH;
        end
      end
      S_FINISH: begin
        result_bank_d = rd_bank_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      step_q        <= '0;
      round_q       <= '0;
      rd_bank_q     <= 1'b0;
      result_bank_q <= 1'b0;
      error_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      step_q        <= step_d;
      round_q       <= round_d;
      rd_bank_q     <= rd_bank_d;
      result_bank_q <= result_bank_d;
      error_q       <= error_d;
      wr_addr_q     <= wr_addr_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  assign done        = (state_q == S_FINISH);
  assign busy        = (state_q != S_IDLE);
  assign error       = error_q;
  assign fu_sel      = step_q;
  assign fu_start    = (state_q == S_LAUNCH);
  assign rd_bank     = rd_bank_q;
  assign wr_bank     = !rd_bank_q;
  assign rd_addr     = rd_addr_of(fu_cnt);
  assign wr_addr     = wr_addr_q;
  assign mem_we      = fu_wr_en && (state_q == S_WAIT);
  // The final bank is exposed in the done cycle itself, then held.
  assign result_bank = (state_q == S_FINISH) ? rd_bank_q : result_bank_q;

endmodule

// File: tb/tb_encoder_pass_sched.sv
// Randomised scenario bench for encoder_pass_sched with a pass-level model.
module tb_encoder_pass_sched;
  import encoder_pass_sched_pkg::*;

  localparam int NF = 3;
  localparam int NR = 2;
  localparam int FW = 2;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst, start, fu_done, fu_wr_en;
  logic [ADDR_W-1:0] fu_cnt;
  logic done, busy, error, fu_start, rd_bank, wr_bank, mem_we, result_bank;
  logic [FW-1:0] fu_sel;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  encoder_pass_sched #(.NUM_FUNCS(NF), .NUM_ROUNDS(NR), .FSEL_W(FW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy), .error(error),
    .fu_sel(fu_sel), .fu_start(fu_start), .fu_done(fu_done), .fu_cnt(fu_cnt),
    .fu_wr_en(fu_wr_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .mem_we(mem_we), .result_bank(result_bank)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-pass write counts for the emulated unit; -1 means the unit never finishes.
  int plan[$];
  int obs_sel[$];
  int obs_bank[$];
  int obs_launch, obs_done, obs_done_cyc, obs_wait_entry, obs_fudone_cyc, obs_bad_gap;
  int obs_extra_launch, obs_extra_done;
  bit obs_err, obs_rb, obs_busy_done, obs_err_launch, obs_busy_after;

  // Emulates the function units for one run; records what the sequencer did.
  task automatic do_run(input int max_cycles, input int abort_pass, input bit toggle_busy);
    int cyc, pass, left;
    bit fin, in_wait, pend;
    obs_sel.delete(); obs_bank.delete();
    obs_done = 0; obs_bad_gap = 0; obs_err = 0; obs_rb = 0; obs_busy_done = 0;
    obs_err_launch = 0; obs_done_cyc = -1; obs_wait_entry = -1; obs_fudone_cyc = -100;
    cyc = 0; pass = 0; left = 0; fin = 0; in_wait = 0; pend = 0;
    @(negedge clk); start = 1'b0; fu_wr_en = 1'b0; fu_done = 1'b0;
    @(negedge clk); start = 1'b1;
    while (!fin && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      fu_wr_en = 1'b0;
      fu_done  = 1'b0;
      if (toggle_busy && cyc == 3) start = 1'b0;
      if (toggle_busy && cyc == 5) start = 1'b1;
      if (pend) begin in_wait = 1; pend = 0; obs_wait_entry = cyc; end
      if (done) begin
        obs_done++; obs_err = error; obs_rb = result_bank; obs_busy_done = busy;
        obs_done_cyc = cyc; fin = 1;
      end else if (fu_start) begin
        if (pass > 0 && cyc != obs_fudone_cyc + 2) obs_bad_gap++;
        obs_sel.push_back(int'(fu_sel));
        obs_bank.push_back(int'(rd_bank));
        if (pass == 0) obs_err_launch = error;
        left = (pass < plan.size()) ? plan[pass] : LINES;
        fu_cnt = '0;
        if (pass == abort_pass) fin = 1;
        pass++; pend = 1; in_wait = 0;
      end else if (in_wait) begin
        if (left > 0 && $urandom_range(0, 3) != 0) begin
          fu_wr_en = 1'b1; fu_cnt = fu_cnt + 1'b1; left--;
        end
        if (left == 0 && $urandom_range(0, 1) == 1) begin
          fu_done = 1'b1; in_wait = 0; obs_fudone_cyc = cyc;
        end
      end
    end
    obs_launch = pass;
  endtask

  task automatic post_run(input int n);
    obs_extra_launch = 0; obs_extra_done = 0;
    fu_wr_en = 1'b0; fu_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) obs_busy_after = busy;
      if (fu_start) obs_extra_launch++;
      if (done) obs_extra_done++;
    end
  endtask

  task automatic test_reset;
    #20;
    checks++;
    if ({done, busy, error, fu_start, rd_bank, result_bank, mem_we} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {done, busy, error, fu_start, rd_bank, result_bank, mem_we});
    end
    checks++;
    if (fu_sel !== '0 || wr_addr !== '0 || wr_bank !== 1'b1) begin
      errors++; $display("FAIL reset_regs: got sel %0d wr_addr %0d wr_bank %0d want 0 0 1", fu_sel, wr_addr, wr_bank);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %0d want 0", busy); end
  endtask

  task automatic test_address;
    int bad, n, v;
    fu_cnt = '0; #1;
    checks++;
    if (rd_addr !== 6'd63) begin errors++; $display("FAIL rd_addr_0: got %0d want 63", rd_addr); end
    fu_cnt = 6'd5; #1;
    checks++;
    if (rd_addr !== 6'd4) begin errors++; $display("FAIL rd_addr_5: got %0d want 4", rd_addr); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      v = $urandom_range(0, LINES - 1);
      fu_cnt = ADDR_W'(v); #1;
      if (int'(rd_addr) != (v + LINES - 1) % LINES) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rd_addr_rand: %0d wrong want 0", bad); end
    fu_wr_en = 1'b1; #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL mem_we_idle: got %0d want 0", mem_we); end
    @(negedge clk); fu_wr_en = 1'b0; start = 1'b0;
    @(negedge clk); start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!fu_start && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!fu_start) begin errors++; $display("FAIL addr_launch: fu_start %0d want 1", fu_start); end
    // Strobes during LAUNCH must be ignored.
    fu_wr_en = 1'b1; fu_done = 1'b1; #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL mem_we_launch: got %0d want 0", mem_we); end
    bad = 0;
    for (int i = 0; i < LINES; i++) begin
      @(negedge clk);
      fu_done = 1'b0;
      if (i == 10) begin
        fu_wr_en = 1'b0; #1;
        if (mem_we !== 1'b0) bad++;
        @(negedge clk);
      end
      fu_wr_en = 1'b1; fu_cnt = ADDR_W'(i); #1;
      if (mem_we !== 1'b1 || int'(wr_addr) != i || wr_bank !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wr_addr_seq: %0d wrong cycles want 0", bad); end
    @(negedge clk); fu_wr_en = 1'b0; #1;
    checks++;
    if (wr_addr !== '0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL wr_addr_wrap: got %0d busy %0d done %0d want 0 1 0", wr_addr, busy, done);
    end
    start = 1'b0; rst = 1'b0; #1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    int bad;
    plan.delete();
    for (int p = 0; p < NF * NR; p++) plan.push_back(LINES);
    do_run(2000, -1, 0);
    post_run(4);
    checks++;
    if (obs_launch != NF * NR || obs_done != 1) begin
      errors++; $display("FAIL nom_count: launches %0d done %0d want %0d 1", obs_launch, obs_done, NF * NR);
    end
    bad = 0;
    for (int p = 0; p < obs_sel.size(); p++)
      if (obs_sel[p] != p % NF || obs_bank[p] != p % 2) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL nom_seq: %0d wrong launches want 0", bad); end
    checks++;
    if (obs_err !== 1'b0 || obs_rb !== 1'b0 || obs_busy_done !== 1'b1) begin
      errors++; $display("FAIL nom_done: err %0d rb %0d busy %0d want 0 0 1", obs_err, obs_rb, obs_busy_done);
    end
    checks++;
    if (obs_bad_gap != 0) begin errors++; $display("FAIL nom_latency: %0d bad gaps want 0", obs_bad_gap); end
    checks++;
    if (obs_busy_after !== 1'b0 || obs_extra_launch != 0 || obs_extra_done != 0 || result_bank !== 1'b0) begin
      errors++; $display("FAIL nom_after: busy %0d launches %0d dones %0d rb %0d want 0 0 0 0",
                         obs_busy_after, obs_extra_launch, obs_extra_done, result_bank);
    end
  endtask

  task automatic test_short_pass;
    for (int k = 0; k < 2; k++) begin
      plan.delete();
      plan.push_back(LINES);
      plan.push_back(k == 0 ? LINES - 1 : LINES + 1);
      do_run(2000, -1, 0);
      post_run(4);
      checks++;
      if (obs_launch != 2 || obs_done != 1 || obs_err !== 1'b1) begin
        errors++; $display("FAIL short_%0d: launches %0d done %0d err %0d want 2 1 1", k, obs_launch, obs_done, obs_err);
      end
      checks++;
      if (obs_done_cyc != obs_fudone_cyc + 1) begin
        errors++; $display("FAIL short_%0d_lat: done at %0d want %0d", k, obs_done_cyc, obs_fudone_cyc + 1);
      end
      checks++;
      if (result_bank !== 1'b1 || obs_extra_launch != 0 || error !== 1'b1) begin
        errors++; $display("FAIL short_%0d_after: rb %0d launches %0d err %0d want 1 0 1", k, result_bank, obs_extra_launch, error);
      end
    end
  endtask

  task automatic test_timeout;
    plan.delete();
    plan.push_back(-1);
    do_run(2000, -1, 0);
    post_run(2);
    checks++;
    if (obs_done != 1 || obs_err !== 1'b1 || obs_launch != 1) begin
      errors++; $display("FAIL timeout_flag: done %0d err %0d launches %0d want 1 1 1", obs_done, obs_err, obs_launch);
    end
    checks++;
    if (obs_done_cyc - obs_wait_entry != TO + 1) begin
      errors++; $display("FAIL timeout_lat: got %0d want %0d", obs_done_cyc - obs_wait_entry, TO + 1);
    end
  endtask

  task automatic test_random;
    int bad_pos, exp_launch, bad;
    bit exp_err, exp_rb;
    for (int r = 0; r < 4; r++) begin
      bad_pos = $urandom_range(0, 8);
      plan.delete();
      for (int p = 0; p < NF * NR; p++)
        plan.push_back(p == bad_pos ? (($urandom_range(0, 1) == 1) ? LINES + 1 : LINES - 1) : LINES);
      exp_err    = (bad_pos < NF * NR);
      exp_launch = exp_err ? bad_pos + 1 : NF * NR;
      exp_rb     = exp_err ? bad_pos[0] : ((NF * NR) % 2 == 1);
      do_run(2000, -1, 0);
      post_run(3);
      bad = 0;
      for (int p = 0; p < obs_sel.size(); p++)
        if (obs_sel[p] != p % NF || obs_bank[p] != p % 2) bad++;
      checks++;
      if (obs_launch != exp_launch || obs_done != 1 || bad != 0) begin
        errors++; $display("FAIL rand_%0d_seq: launches %0d done %0d badseq %0d want %0d 1 0", r, obs_launch, obs_done, bad, exp_launch);
      end
      checks++;
      if (obs_err !== exp_err || obs_rb !== exp_rb || obs_extra_launch != 0) begin
        errors++; $display("FAIL rand_%0d_res: err %0d rb %0d extra %0d want %0d %0d 0", r, obs_err, obs_rb, obs_extra_launch, exp_err, exp_rb);
      end
    end
  endtask

  task automatic test_start_handling;
    plan.delete();
    plan.push_back(LINES - 1);
    do_run(2000, -1, 0);
    post_run(2);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL start_pre_err: err %0d want 1", error); end
    plan.delete();
    do_run(2000, -1, 1);
    post_run(10);
    checks++;
    if (obs_err_launch !== 1'b0 || obs_err !== 1'b0) begin
      errors++; $display("FAIL start_clear: err@launch %0d err@done %0d want 0 0", obs_err_launch, obs_err);
    end
    checks++;
    if (obs_launch != NF * NR || obs_done != 1 || obs_extra_launch != 0 || obs_extra_done != 0) begin
      errors++; $display("FAIL start_busy: launches %0d done %0d extra %0d/%0d want %0d 1 0 0",
                         obs_launch, obs_done, obs_extra_launch, obs_extra_done, NF * NR);
    end
  endtask

  task automatic test_reset_mid_run;
    plan.delete();
    do_run(2000, NF + 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fu_wr_en = 1'b1; fu_cnt = ADDR_W'(i + 1);
    end
    @(negedge clk); fu_wr_en = 1'b0; #1;
    checks++;
    if (busy !== 1'b1 || fu_sel !== 2'd1 || wr_addr !== 6'd3) begin
      errors++; $display("FAIL mid_pre: busy %0d sel %0d wr_addr %0d want 1 1 3", busy, fu_sel, wr_addr);
    end
    start = 1'b0; rst = 1'b0; #1;
    checks++;
    if ({done, busy, error, fu_start, rd_bank, result_bank} !== 6'b0 || fu_sel !== '0 || wr_addr !== '0) begin
      errors++; $display("FAIL mid_reset: flags %b sel %0d wr_addr %0d want 0 0 0",
                         {done, busy, error, fu_start, rd_bank, result_bank}, fu_sel, wr_addr);
    end
    @(negedge clk); rst = 1'b1;
    post_run(6);
    checks++;
    if (obs_extra_done != 0 || obs_extra_launch != 0) begin
      errors++; $display("FAIL mid_nodone: dones %0d launches %0d want 0 0", obs_extra_done, obs_extra_launch);
    end
    do_run(2000, -1, 0);
    checks++;
    if (obs_launch != NF * NR || obs_done != 1 || obs_err !== 1'b0 || obs_rb !== 1'b0) begin
      errors++; $display("FAIL mid_rerun: launches %0d done %0d err %0d rb %0d want %0d 1 0 0",
                         obs_launch, obs_done, obs_err, obs_rb, NF * NR);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; fu_done = 1'b0; fu_wr_en = 1'b0; fu_cnt = '0;
    test_reset;
    test_address;
    test_nominal;
    test_short_pass;
    test_timeout;
    test_random;
    test_start_handling;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
